// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding and small elaboration helpers for the clock set controller.
package clock_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_HR  = 2'd1;
  localparam logic [1:0] ST_SET_MIN = 2'd2;
  localparam logic [1:0] ST_SET_SEC = 2'd3;

  typedef enum logic [1:0] {
    S_RUN     = ST_RUN,
    S_SET_HR  = ST_SET_HR,
    S_SET_MIN = ST_SET_MIN,
    S_SET_SEC = ST_SET_SEC
  } state_e;

  // Mode button walks the states in a fixed ring.
  function automatic state_e next_mode(input state_e s);
    case (s)
      S_RUN:     return S_SET_HR;
      S_SET_HR:  return S_SET_MIN;
      S_SET_MIN: return S_SET_SEC;
      default:   return S_RUN;
    endcase
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counting debouncer and single-cycle press detector for one button.
module button_debounce
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned    CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync_p0;
  logic          r_sync_p1;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0  <= 1'b0;
      r_sync_p1  <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // stage p0/p1: metastability guard on the raw pin
      r_sync_p0  <= raw;
      r_sync_p1  <= r_sync_p0;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      // stage debounce: level only moves after an unbroken run of disagreement
      if (r_sync_p1 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync_p1;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_stable;
  assign press = r_press;

endmodule

// File: rtl/clock_set_controller.sv
// Clock control front end: seconds prescaler, button debouncing, RUN/SET mode FSM and increment steering.
// Optional feature: define AUTO_REPEAT_EN to get held-button auto-repeat on the increment button.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_tick,
  output logic       set_hr,
  output logic       set_min,
  output logic       set_sec,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [1:0] mode
);

  localparam int unsigned   PW         = cnt_w(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic   w_mode_level;
  logic   w_mode_press;
  logic   w_inc_level;
  logic   w_inc_press;
  logic   w_rep_fire;
  logic   w_inc_fire;
  logic   w_unused_levels;
  state_e w_state_nxt;

  state_e        r_state;
  logic [PW-1:0] r_presc;
  logic          r_sec_tick;
  logic          r_set_hr;
  logic          r_set_min;
  logic          r_set_sec;
  logic          r_inc_hr;
  logic          r_inc_min;
  logic          r_inc_sec;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .level (w_mode_level),
    .press (w_mode_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_inc (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_inc),
    .level (w_inc_level),
    .press (w_inc_press)
  );

  assign w_unused_levels = w_mode_level ^ w_inc_level;

  // A mode press always takes priority; a coincident inc press is dropped.
  assign w_state_nxt = w_mode_press ? next_mode(r_state) : r_state;
  assign w_inc_fire  = !w_mode_press && (r_state != S_RUN) && (w_inc_press || w_rep_fire);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned   RW        = cnt_w(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic          r_rep_act;
  logic          r_rep_first;
  logic [RW-1:0] r_rep_cnt;

  assign w_rep_fire = r_rep_act && w_inc_level &&
                      (r_rep_cnt == (r_rep_first ? RPT_FIRST : RPT_NEXT));

  // Counts cycles since the last issued pulse while inc stays held in one set state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_act   <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_mode_press || (r_state == S_RUN)) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= '0;
    end else if (w_inc_press) begin
      r_rep_act   <= 1'b1;
      r_rep_first <= 1'b1;
      r_rep_cnt   <= '0;
    end else if (r_rep_act) begin
      if (!w_inc_level) begin
        r_rep_act <= 1'b0;
        r_rep_cnt <= '0;
      end else if (w_rep_fire) begin
        r_rep_first <= 1'b0;
        r_rep_cnt   <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
      r_set_hr   <= 1'b0;
      r_set_min  <= 1'b0;
      r_set_sec  <= 1'b0;
      r_inc_hr   <= 1'b0;
      r_inc_min  <= 1'b0;
      r_inc_sec  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_set_hr  <= (w_state_nxt == S_SET_HR);
      r_set_min <= (w_state_nxt == S_SET_MIN);
      r_set_sec <= (w_state_nxt == S_SET_SEC);
      r_inc_hr  <= w_inc_fire && (r_state == S_SET_HR);
      r_inc_min <= w_inc_fire && (r_state == S_SET_MIN);
      r_inc_sec <= w_inc_fire && (r_state == S_SET_SEC);
      // Prescaler parks at zero whenever RUN is not being held, so re-entry restarts a full second.
      if ((r_state == S_RUN) && !w_mode_press) begin
        if (r_presc == PRESC_LAST) begin
          r_presc    <= '0;
          r_sec_tick <= 1'b1;
        end else begin
          r_presc    <= r_presc + PW'(1);
          r_sec_tick <= 1'b0;
        end
      end else begin
        r_presc    <= '0;
        r_sec_tick <= 1'b0;
      end
    end
  end

  assign sec_tick = r_sec_tick;
  assign set_hr   = r_set_hr;
  assign set_min  = r_set_min;
  assign set_sec  = r_set_sec;
  assign inc_hr   = r_inc_hr;
  assign inc_min  = r_inc_min;
  assign inc_sec  = r_inc_sec;
  assign mode     = r_state;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller: directed scenarios followed by random button traffic.
`timescale 1ns/1ps
module tb_clock_set_controller;

  localparam int CLK_DIV = 10;
  localparam int DB      = 4;
`ifdef AUTO_REPEAT_EN
  localparam int RD      = 20;
  localparam int RP      = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_tick, set_hr, set_min, set_sec, inc_hr, inc_min, inc_sec;
  logic [1:0] mode;

  always #5 clk = ~clk;

  clock_set_controller #(
    .CLK_DIV         (CLK_DIV),
    .DEBOUNCE_CYCLES (DB)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_tick (sec_tick),
    .set_hr   (set_hr),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .inc_hr   (inc_hr),
    .inc_min  (inc_min),
    .inc_sec  (inc_sec),
    .mode     (mode)
  );

  // Expected pulse event: cycle index and {sec_tick, inc_hr, inc_min, inc_sec}.
  typedef struct packed {
    int         cyc;
    logic [3:0] pulses;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // ---------------- reference model ----------------
  // A button's stable level flips at an edge when the synchronized value seen at
  // each of the last DB edges disagreed with it; synchronized value at edge n is raw at n-2.
  bit mh[0:DB+1];
  bit ih[0:DB+1];
  bit st_m, st_i, rose_m, rose_i, pm, pi;
  int m_mode = 0;
  int run_start = 0;
  bit armed = 0;
  int due = 0;

  function automatic bit window_differs(input bit h[0:DB+1], input bit st);
    for (int k = 2; k < DB + 2; k++)
      if (h[k] == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int         old;
    bit         fm, fi;
    logic [3:0] p;
    cyc++;
    if (reset) begin
      for (int k = 0; k < DB + 2; k++) begin
        mh[k] = 1'b0;
        ih[k] = 1'b0;
      end
      st_m = 0; st_i = 0; rose_m = 0; rose_i = 0; pm = 0; pi = 0;
      m_mode = 0; armed = 0; run_start = cyc;
    end else begin
      old = m_mode;
      p = 4'b0000;
      if (pm) begin
        m_mode = (m_mode + 1) % 4;
        armed = 0;
        if (m_mode == 0) run_start = cyc;
      end else if (old == 0) begin
        if (cyc > run_start && (cyc - run_start) % CLK_DIV == 0) p = 4'b1000;
      end else begin
        if (pi) begin
          p = 4'b0001 << (3 - old);
`ifdef AUTO_REPEAT_EN
          armed = 1;
          due = cyc + RD;
`endif
        end
`ifdef AUTO_REPEAT_EN
        else if (armed) begin
          if (!st_i) armed = 0;
          else if (cyc == due) begin
            p = 4'b0001 << (3 - old);
            due = cyc + RP;
          end
        end
`endif
      end
      if (p != 4'b0000) sb.push_back('{cyc: cyc, pulses: p});

      for (int k = DB + 1; k > 0; k--) begin
        mh[k] = mh[k-1];
        ih[k] = ih[k-1];
      end
      mh[0] = btn_mode;
      ih[0] = btn_inc;
      pm = rose_m;
      pi = rose_i;
      fm = window_differs(mh, st_m);
      fi = window_differs(ih, st_i);
      rose_m = fm && !st_m;
      rose_i = fi && !st_i;
      if (fm) st_m = !st_m;
      if (fi) st_i = !st_i;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0] d;
    logic [4:0] exp_state;
    exp_t       e;
    d = {sec_tick, inc_hr, inc_min, inc_sec};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse cyc %0d: got none, required %b", e.cyc, e.pulses);
    end
    if (d !== 4'b0000) begin
      vectors++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        if (d !== e.pulses) begin
          miscompares++;
          $display("FAIL pulse_kind cyc %0d: got %b, required %b", cyc, d, e.pulses);
        end
      end else begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc %0d: got %b, required 0000", cyc, d);
      end
    end
    exp_state = {2'(m_mode), m_mode == 1, m_mode == 2, m_mode == 3};
    vectors++;
    if ({mode, set_hr, set_min, set_sec} !== exp_state) begin
      miscompares++;
      $display("FAIL mode_state cyc %0d: got %b, required %b", cyc,
               {mode, set_hr, set_min, set_sec}, exp_state);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode(input int w, input int gap);
    btn_mode = 1'b1; step(w); btn_mode = 1'b0; step(gap);
  endtask

  task automatic pulse_inc(input int w, input int gap);
    btn_inc = 1'b1; step(w); btn_inc = 1'b0; step(gap);
  endtask

  initial begin
    reset = 1'b1;
    step(3);
    @(negedge clk);
    vectors++;
    if ({sec_tick, set_hr, set_min, set_sec, inc_hr, inc_min, inc_sec, mode} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required 000000000",
               {sec_tick, set_hr, set_min, set_sec, inc_hr, inc_min, inc_sec, mode});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step(35);                       // free-running ticks
    pulse_mode(3, 12);              // glitch, ignored
    pulse_mode(10, 12);             // SET_HR
    pulse_mode(6, 12);              // SET_MIN
    pulse_inc(6, 15);               // single inc_min
    pulse_mode(6, 12);              // SET_SEC
    pulse_mode(6, 25);              // RUN, prescaler restarts
    pulse_inc(6, 15);               // ignored in RUN
    pulse_mode(6, 12);              // SET_HR
    btn_mode = 1'b1; btn_inc = 1'b1; step(6);
    btn_mode = 1'b0; btn_inc = 1'b0; step(15);   // mode wins -> SET_MIN
    pulse_mode(6, 12);              // SET_SEC
    pulse_inc(50, 20);              // held inc
    reset = 1'b1; step(1); reset = 1'b0; step(20);

    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 7)       pulse_mode($urandom_range(1, 8), $urandom_range(0, 20));
      else if (r < 14) pulse_inc($urandom_range(1, 8), $urandom_range(0, 20));
      else if (r < 17) pulse_inc($urandom_range(20, 60), $urandom_range(0, 20));
      else if (r < 19) begin
        btn_mode = 1'b1; btn_inc = 1'b1; step($urandom_range(1, 8));
        btn_mode = 1'b0; step($urandom_range(0, 6));
        btn_inc = 1'b0; step($urandom_range(0, 20));
      end else begin
        reset = 1'b1; step($urandom_range(1, 3)); reset = 1'b0; step($urandom_range(0, 20));
      end
    end
    step(40);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL leftover_pulse cyc %0d: got none, required %b", e.cyc, e.pulses);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
